// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the pipeline-stage register: state encoding,
// default field widths and a ctrl/data beat packing helper.
package pipe_pkg;

  // Occupancy of the stage; PIPE_SKID is only reachable when the skid slot is built.
  typedef enum logic [1:0] {
    PIPE_EMPTY = 2'b00,
    PIPE_FULL  = 2'b01,
    PIPE_SKID  = 2'b10
  } pipe_state_t;

  localparam int PIPE_CTRL_W_DEF      = 16;
  localparam int PIPE_DATA_W_DEF      = 128;
  localparam int PIPE_STALL_CNT_W_DEF = 16;

  // One beat at the default widths, control field in the upper bits.
  typedef struct packed {
    logic [PIPE_CTRL_W_DEF-1:0] ctrl;
    logic [PIPE_DATA_W_DEF-1:0] data;
  } pipe_beat_t;

  // Packs a control and data field into a default-width beat.
  function automatic pipe_beat_t pipe_beat_pack(
    input logic [PIPE_CTRL_W_DEF-1:0] ctrl_f,
    input logic [PIPE_DATA_W_DEF-1:0] data_f
  );
    pipe_beat_t beat;
    beat.ctrl = ctrl_f;
    beat.data = data_f;
    return beat;
  endfunction

  // True when the state holds at least one beat for downstream.
  function automatic logic pipe_state_holds_beat(input pipe_state_t s);
    return s != PIPE_EMPTY;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle of the pipeline-stage register. The slave modport is the
// stage itself; the master modport is the surrounding pipeline (upstream
// producer, downstream consumer and hazard unit taken together).
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int CTRL_W      = PIPE_CTRL_W_DEF,
  parameter int DATA_W      = PIPE_DATA_W_DEF,
  parameter int STALL_CNT_W = PIPE_STALL_CNT_W_DEF
);

  logic                   in_valid;
  logic                   in_ready;
  logic [CTRL_W-1:0]      in_ctrl;
  logic [DATA_W-1:0]      in_data;
  logic                   flush;
  logic                   out_valid;
  logic                   out_ready;
  logic [CTRL_W-1:0]      out_ctrl;
  logic [DATA_W-1:0]      out_data;
  logic [STALL_CNT_W-1:0] stall_cnt;
  logic                   stall_cnt_clr;

  modport master (
    output in_valid, in_ctrl, in_data, flush, out_ready, stall_cnt_clr,
    input  in_ready, out_valid, out_ctrl, out_data, stall_cnt
  );

  modport slave (
    input  in_valid, in_ctrl, in_data, flush, out_ready, stall_cnt_clr,
    output in_ready, out_valid, out_ctrl, out_data, stall_cnt
  );

endinterface

// File: rtl/pipe_stage_reg_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear beats increment and
// the count sticks at all-ones instead of wrapping.
module pipe_sat_cnt
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_STALL_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  // Count events, clear on request, hold once the top value is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline-stage register: carries a control and a data field
// between two stages with valid/ready, synchronous flush and one cycle of
// latency. Control is forced to zero whenever no beat is held, so downstream
// enables need no valid gating. Build option PIPE_STAGE_SKID_EN adds a skid
// slot so in_ready becomes a register while keeping full throughput.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W              = PIPE_CTRL_W_DEF,
  parameter int DATA_W              = PIPE_DATA_W_DEF,
  parameter int CLEAR_DATA_ON_FLUSH = 1,
  parameter int STALL_CNT_W         = PIPE_STALL_CNT_W_DEF
) (
  input logic             clk,
  input logic             rst_n,
  pipe_stage_reg_if.slave bus
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } beat_t;

  pipe_state_t state_q;
  logic        valid_q;
  beat_t       main_q;
  beat_t       in_beat;
  logic        stall_now;

`ifdef PIPE_STAGE_SKID_EN
  beat_t       skid_q;
  logic        ready_q;
`endif

  assign in_beat = {bus.in_ctrl, bus.in_data};

  // Occupancy FSM with registered valid, main register and optional skid slot;
  // flush overrides every transition and drops whatever is offered alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PIPE_EMPTY;
      valid_q <= 1'b0;
      main_q  <= '0;
`ifdef PIPE_STAGE_SKID_EN
      skid_q  <= '0;
      ready_q <= 1'b1;
`endif
    end else if (bus.flush) begin
      state_q     <= PIPE_EMPTY;
      valid_q     <= 1'b0;
      main_q.ctrl <= '0;
      if (CLEAR_DATA_ON_FLUSH != 0) begin
        main_q.data <= '0;
      end
`ifdef PIPE_STAGE_SKID_EN
      skid_q.ctrl <= '0;
      if (CLEAR_DATA_ON_FLUSH != 0) begin
        skid_q.data <= '0;
      end
      ready_q     <= 1'b1;
`endif
    end else begin
      case (state_q)
        PIPE_EMPTY: begin
          if (bus.in_valid) begin
            main_q  <= in_beat;
            valid_q <= 1'b1;
            state_q <= PIPE_FULL;
          end
        end
        PIPE_FULL: begin
          if (bus.out_ready) begin
            if (bus.in_valid) begin
              main_q <= in_beat;
            end else begin
              main_q.ctrl <= '0;
              valid_q     <= 1'b0;
              state_q     <= PIPE_EMPTY;
            end
          end
`ifdef PIPE_STAGE_SKID_EN
          else if (bus.in_valid) begin
            skid_q  <= in_beat;
            ready_q <= 1'b0;
            state_q <= PIPE_SKID;
          end
`endif
        end
`ifdef PIPE_STAGE_SKID_EN
        PIPE_SKID: begin
          if (bus.out_ready) begin
            main_q  <= skid_q;
            ready_q <= 1'b1;
            state_q <= PIPE_FULL;
          end
        end
`endif
        default: begin
          main_q.ctrl <= '0;
          valid_q     <= 1'b0;
          state_q     <= PIPE_EMPTY;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  assign bus.in_ready = ready_q;
`else
  assign bus.in_ready = bus.out_ready | ~valid_q;
`endif

  assign bus.out_valid = valid_q;
  assign bus.out_ctrl  = main_q.ctrl;
  assign bus.out_data  = main_q.data;

  // A held beat that downstream refuses is one back-pressured cycle.
  assign stall_now = valid_q & ~bus.out_ready;

  pipe_sat_cnt #(
    .WIDTH(STALL_CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_now),
    .clr   (bus.stall_cnt_clr),
    .count (bus.stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: two instances share one stimulus stream, one
// clearing data on flush with a 16-bit stall counter, one holding data on
// flush with a 4-bit counter. Works with or without PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  localparam int CNT_A_MAX = 65535;
  localparam int CNT_B_MAX = 15;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [15:0]  in_ctrl;
  logic [127:0] in_data;
  logic         flush;
  logic         out_ready;
  logic         stall_cnt_clr;

  int checks = 0;
  int errors = 0;

  pipe_beat_t   mq[$];
  logic [127:0] shown_a;
  logic [127:0] shown_b;
  int           cnt_a;
  int           cnt_b;
  logic         pending;
  logic         acc;
  logic         ordy_k;

  typedef struct {
    logic         iv;
    logic [15:0]  ctrl;
    logic [127:0] data;
    logic         fl;
    logic         ordy;
    logic         clr;
    logic         exp_valid;
    logic [15:0]  exp_ctrl;
    logic [127:0] exp_data_a;
    logic [127:0] exp_data_b;
    int           exp_cnt;
  } vec_t;

  vec_t vecs[13];

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.CTRL_W(16), .DATA_W(128), .STALL_CNT_W(16)) bus_a ();
  pipe_stage_reg_if #(.CTRL_W(16), .DATA_W(128), .STALL_CNT_W(4))  bus_b ();

  assign bus_a.in_valid      = in_valid;
  assign bus_a.in_ctrl       = in_ctrl;
  assign bus_a.in_data       = in_data;
  assign bus_a.flush         = flush;
  assign bus_a.out_ready     = out_ready;
  assign bus_a.stall_cnt_clr = stall_cnt_clr;
  assign bus_b.in_valid      = in_valid;
  assign bus_b.in_ctrl       = in_ctrl;
  assign bus_b.in_data       = in_data;
  assign bus_b.flush         = flush;
  assign bus_b.out_ready     = out_ready;
  assign bus_b.stall_cnt_clr = stall_cnt_clr;

  pipe_stage_reg #(
    .CTRL_W(16), .DATA_W(128), .CLEAR_DATA_ON_FLUSH(1), .STALL_CNT_W(16)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );

  pipe_stage_reg #(
    .CTRL_W(16), .DATA_W(128), .CLEAR_DATA_ON_FLUSH(0), .STALL_CNT_W(4)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  task automatic applyStimulus(input logic iv, input logic [15:0] c, input logic [127:0] d,
                               input logic fl, input logic ordy, input logic clr);
    in_valid      = iv;
    in_ctrl       = c;
    in_data       = d;
    flush         = fl;
    out_ready     = ordy;
    stall_cnt_clr = clr;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: the stage is a FIFO of capacity 2 (skid) or 1 (no skid).
  function automatic logic model_in_ready();
    if (SKID) return mq.size() < 2;
    return out_ready || (mq.size() == 0);
  endfunction

  task automatic model_reset();
    mq.delete();
    shown_a = '0;
    shown_b = '0;
    cnt_a   = 0;
    cnt_b   = 0;
  endtask

  task automatic model_step();
    logic ov, fin, fout;
    pipe_beat_t dropped;
    ov   = (mq.size() != 0);
    fin  = in_valid && model_in_ready();
    fout = ov && out_ready;
    if (stall_cnt_clr) begin
      cnt_a = 0;
      cnt_b = 0;
    end else if (ov && !out_ready) begin
      if (cnt_a < CNT_A_MAX) cnt_a++;
      if (cnt_b < CNT_B_MAX) cnt_b++;
    end
    if (flush) begin
      mq.delete();
      shown_a = '0;
    end else begin
      if (fout) dropped = mq.pop_front();
      if (fin) mq.push_back(pipe_beat_pack(in_ctrl, in_data));
      if (mq.size() != 0) begin
        shown_a = mq[0].data;
        shown_b = mq[0].data;
      end
    end
  endtask

  task automatic check_model();
    logic ev, er;
    logic [15:0] ec;
    ev = (mq.size() != 0);
    ec = '0;
    if (ev) ec = mq[0].ctrl;
    er = model_in_ready();
    checkOutput("a.out_valid", bus_a.out_valid, ev);
    checkOutput("a.out_ctrl",  bus_a.out_ctrl,  ec);
    checkOutput("a.out_data",  bus_a.out_data,  shown_a);
    checkOutput("a.in_ready",  bus_a.in_ready,  er);
    checkOutput("a.stall_cnt", bus_a.stall_cnt, cnt_a);
    checkOutput("b.out_valid", bus_b.out_valid, ev);
    checkOutput("b.out_ctrl",  bus_b.out_ctrl,  ec);
    checkOutput("b.out_data",  bus_b.out_data,  shown_b);
    checkOutput("b.in_ready",  bus_b.in_ready,  er);
    checkOutput("b.stall_cnt", bus_b.stall_cnt, cnt_b);
  endtask

  // Inputs already applied after a falling edge: check, clock, step the model.
  task automatic cycle();
    #1 check_model();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 16'h0, 128'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    #1 check_model();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 16'h0, 128'h0, 1'b0, 1'b0, 1'b0);

    //        iv ctrl    data        fl ordy clr valid ctrl   data_a     data_b     cnt
    vecs[0]  = '{1, 16'h01, 128'h101,  0, 1, 0, 1, 16'h01, 128'h101,  128'h101,  0};
    vecs[1]  = '{1, 16'h02, 128'h102,  0, 1, 0, 1, 16'h02, 128'h102,  128'h102,  0};
    vecs[2]  = '{0, 16'h00, 128'h0,    0, 0, 0, 1, 16'h02, 128'h102,  128'h102,  1};
    vecs[3]  = '{0, 16'h00, 128'h0,    0, 0, 0, 1, 16'h02, 128'h102,  128'h102,  2};
    vecs[4]  = '{0, 16'h00, 128'h0,    0, 1, 0, 0, 16'h00, 128'h102,  128'h102,  2};
    vecs[5]  = '{0, 16'h00, 128'h0,    0, 0, 0, 0, 16'h00, 128'h102,  128'h102,  2};
    vecs[6]  = '{1, 16'h33, 128'hDEAD, 0, 0, 0, 1, 16'h33, 128'hDEAD, 128'hDEAD, 2};
    vecs[7]  = '{1, 16'h44, 128'h44,   1, 0, 0, 0, 16'h00, 128'h0,    128'hDEAD, 3};
    vecs[8]  = '{0, 16'h00, 128'h0,    0, 0, 1, 0, 16'h00, 128'h0,    128'hDEAD, 0};
    vecs[9]  = '{1, 16'h55, 128'h55,   0, 1, 0, 1, 16'h55, 128'h55,   128'h55,   0};
    vecs[10] = '{0, 16'h00, 128'h0,    0, 0, 1, 1, 16'h55, 128'h55,   128'h55,   0};
    vecs[11] = '{0, 16'h00, 128'h0,    0, 0, 0, 1, 16'h55, 128'h55,   128'h55,   1};
    vecs[12] = '{0, 16'h00, 128'h0,    0, 1, 0, 0, 16'h00, 128'h55,   128'h55,   1};

    do_reset();
    $display("[TB] table vectors");
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].iv, vecs[i].ctrl, vecs[i].data, vecs[i].fl, vecs[i].ordy, vecs[i].clr);
      cycle();
      #1;
      checkOutput($sformatf("vec%0d.valid", i), bus_a.out_valid, vecs[i].exp_valid);
      checkOutput($sformatf("vec%0d.ctrl", i),  bus_a.out_ctrl,  vecs[i].exp_ctrl);
      checkOutput($sformatf("vec%0d.data_a", i), bus_a.out_data, vecs[i].exp_data_a);
      checkOutput($sformatf("vec%0d.data_b", i), bus_b.out_data, vecs[i].exp_data_b);
      checkOutput($sformatf("vec%0d.cnt_a", i), bus_a.stall_cnt, vecs[i].exp_cnt);
      checkOutput($sformatf("vec%0d.cnt_b", i), bus_b.stall_cnt, vecs[i].exp_cnt);
    end

    $display("[TB] streaming 8 beats");
    do_reset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 16'(i), 128'(32'h100 + i), 1'b0, 1'b1, 1'b0);
      cycle();
      #1;
      checkOutput($sformatf("stream%0d.valid", i), bus_a.out_valid, 1'b1);
      checkOutput($sformatf("stream%0d.ctrl", i), bus_a.out_ctrl, 16'(i));
      checkOutput($sformatf("stream%0d.data", i), bus_a.out_data, 128'(32'h100 + i));
      checkOutput($sformatf("stream%0d.stall", i), bus_a.stall_cnt, 0);
    end
    applyStimulus(1'b0, 16'h0, 128'h0, 1'b0, 1'b1, 1'b0);
    cycle();
    #1 checkOutput("stream.end_valid", bus_a.out_valid, 1'b0);

    $display("[TB] stall counter saturation");
    applyStimulus(1'b0, 16'h0, 128'h0, 1'b0, 1'b1, 1'b1);
    cycle();
    applyStimulus(1'b1, 16'h5A, 128'h5A, 1'b0, 1'b0, 1'b0);
    cycle();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 16'h0, 128'h0, 1'b0, 1'b0, 1'b0);
      cycle();
    end
    #1;
    checkOutput("sat.b_stops_at_15", bus_b.stall_cnt, 15);
    checkOutput("sat.a_counts_20", bus_a.stall_cnt, 20);
    applyStimulus(1'b0, 16'h0, 128'h0, 1'b0, 1'b0, 1'b1);
    cycle();
    #1;
    checkOutput("sat.clr_during_stall_b", bus_b.stall_cnt, 0);
    checkOutput("sat.clr_during_stall_a", bus_a.stall_cnt, 0);
    applyStimulus(1'b0, 16'h0, 128'h0, 1'b0, 1'b0, 1'b0);
    cycle();
    #1 checkOutput("sat.resume_b", bus_b.stall_cnt, 1);

    $display("[TB] back-pressure with second beat offered");
    applyStimulus(1'b0, 16'h0, 128'h0, 1'b0, 1'b1, 1'b1);
    cycle();
    applyStimulus(1'b1, 16'h00A, 128'hA, 1'b0, 1'b1, 1'b0);
    cycle();
    pending = 1'b1;
    for (int k = 0; k < 6; k++) begin
      ordy_k = (k >= 3);
      applyStimulus(pending, 16'h00B, 128'hB, 1'b0, ordy_k, 1'b0);
      acc = pending && model_in_ready();
      cycle();
      if (acc) pending = 1'b0;
      #1;
      if (k == 0) checkOutput("bp.in_ready_low", bus_a.in_ready, 1'b0);
      if (k == 2) begin
        checkOutput("bp.hold_a", bus_a.out_ctrl, 16'h00A);
        checkOutput("bp.stall_3", bus_a.stall_cnt, 3);
      end
      if (k == 3) begin
        checkOutput("bp.then_b_valid", bus_a.out_valid, 1'b1);
        checkOutput("bp.then_b", bus_a.out_ctrl, 16'h00B);
      end
      if (k == 4) checkOutput("bp.drained", bus_a.out_valid, 1'b0);
    end

    $display("[TB] flush with two beats held");
    applyStimulus(1'b1, 16'h0C1, 128'hC1, 1'b0, 1'b1, 1'b0);
    cycle();
    applyStimulus(1'b1, 16'h0C2, 128'hC2, 1'b0, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b1, 16'h0C3, 128'hC3, 1'b1, 1'b1, 1'b0);
    cycle();
    #1;
    checkOutput("flush.a_valid", bus_a.out_valid, 1'b0);
    checkOutput("flush.a_ctrl", bus_a.out_ctrl, 16'h0);
    checkOutput("flush.a_data_zero", bus_a.out_data, 128'h0);
    checkOutput("flush.a_in_ready", bus_a.in_ready, 1'b1);
    checkOutput("flush.b_data_held", bus_b.out_data, 128'hC1);
    checkOutput("flush.b_valid", bus_b.out_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 16'h0, 128'h0, 1'b0, 1'b1, 1'b0);
      cycle();
      #1 checkOutput($sformatf("flush.no_ghost%0d", i), bus_a.out_valid, 1'b0);
    end

    $display("[TB] random traffic");
    for (int k = 0; k < 400; k++) begin
      if ((k % 100) < 25) ordy_k = ($urandom_range(0, 5) == 0);
      else ordy_k = ($urandom_range(0, 3) != 0);
      applyStimulus($urandom_range(0, 3) != 0, 16'($urandom()),
                    {$urandom(), $urandom(), $urandom(), $urandom()},
                    $urandom_range(0, 19) == 0, ordy_k, $urandom_range(0, 40) == 0);
      cycle();
    end

    $display("[TB] asynchronous reset mid-stream");
    applyStimulus(1'b1, 16'h77, 128'h7777, 1'b0, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b0, 16'h0, 128'h0, 1'b0, 1'b0, 1'b0);
    cycle();
    cycle();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("areset.a_valid", bus_a.out_valid, 1'b0);
    checkOutput("areset.a_ctrl", bus_a.out_ctrl, 16'h0);
    checkOutput("areset.a_data", bus_a.out_data, 128'h0);
    checkOutput("areset.a_stall", bus_a.stall_cnt, 0);
    checkOutput("areset.a_in_ready", bus_a.in_ready, 1'b1);
    checkOutput("areset.b_data", bus_b.out_data, 128'h0);
    checkOutput("areset.b_stall", bus_b.stall_cnt, 0);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 16'(16'h90 + i), 128'(32'h900 + i), 1'b0, 1'b1, 1'b0);
      cycle();
    end
    applyStimulus(1'b0, 16'h0, 128'h0, 1'b0, 1'b1, 1'b0);
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline-stage register that succeeds the fixed-field inter-stage registers (IF/ID, ID/EXE, EXE/MEM, MEM/WB). It carries an opaque control field and a data field between two pipeline stages with a valid/ready handshake, synchronous flush and one-cycle latency. An optional skid slot provides full throughput with a registered `in_ready`. A saturating stall counter supports hazard-unit profiling.

## Interface
- `CTRL_W`, 16: control-field width (wb_en, mem_read, mem_write, br, exe_cmd, …); zeroed on bubbles.
- `DATA_W`, 128: data-field width (pc, operands, reg ids, …).
- `CLEAR_DATA_ON_FLUSH`, 1: 1 = flush also zeroes data registers; 0 = data held.
- `STALL_CNT_W`, 16: stall-counter width.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: upstream offers a beat.
- `in_ready` out 1: stage accepts a beat this cycle.
- `in_ctrl` in CTRL_W: upstream control field.
- `in_data` in DATA_W: upstream data field.
- `flush` in 1: synchronous kill of all held and incoming beats.
- `out_valid` out 1: downstream beat valid.
- `out_ready` in 1: downstream accepts.
- `out_ctrl` out CTRL_W: held control; all-zero whenever `out_valid`=0.
- `out_data` out DATA_W: held data.
- `stall_cnt` out STALL_CNT_W: saturating count of back-pressured cycles.
- `stall_cnt_clr` in 1: synchronous counter clear.

## Operation
- Beat transfers in on `in_valid & in_ready`. Beat transfers out on `out_valid & out_ready`.
- Main register (`out_*`) plus, with skid enabled, one skid slot. State: EMPTY, FULL, SKID (SKID only with macro).
- EMPTY:
  - `in_valid` → load main, go to FULL.
- FULL:
  - `out_ready & in_valid` → main ← input, stay FULL.
  - `out_ready & !in_valid` → EMPTY; `out_ctrl` ← 0.
  - `!out_ready & in_valid` → skid ← input, go to SKID.
  - Otherwise hold.
- SKID:
  - `in_ready`=0.
  - `out_ready` → main ← skid, go to FULL.
  - Otherwise hold.
- Flush: priority over every transition.
  - Next state EMPTY; `out_valid` 0; main and skid ctrl 0.
  - Data zeroed if `CLEAR_DATA_ON_FLUSH`, else held.
  - An input beat handshaken in the flush cycle is discarded; upstream treats it as consumed.
- Bubble rule: whenever `out_valid`=0, `out_ctrl` is all-zero. Downstream needs no valid gating of wb/mem enables.
- Stall counter:
  - +1 each cycle with `out_valid & !out_ready`.
  - Saturates at all-ones, no wrap.
  - `stall_cnt_clr` wins over increment; cleared value reads 0 next cycle.
  - Flush does not affect it.

## Timing
- Reset (`rst_n`=0, async):
  - State EMPTY.
  - `out_valid`=0, `out_ctrl`=0, `out_data`=0, skid slot 0, `stall_cnt`=0.
  - `in_ready`=1 once `rst_n` deasserts.
- Reset mid-transfer drops all held beats; no partial state survives.
- Latency: input at edge N is visible on `out_*` after edge N (1 cycle). Throughput 1 beat/cycle under continuous `out_ready`.
- `in_ready`:
  - With skid: registered, = (state != SKID).
  - Without skid: combinational `out_ready | !out_valid`.
- `out_*` always registered; no combinational in→out path.
- SKID drains one beat per cycle of `out_ready`. Beat order is strictly preserved.
- Simultaneous flush + `stall_cnt_clr`: both take effect.

## Configuration
- `PIPE_STAGE_SKID_EN` defined:
  - Skid slot and SKID state present.
  - `in_ready` registered; breaks the ready timing path across the stage.
- Undefined:
  - Single register, states EMPTY/FULL only.
  - `in_ready` combinational as above.
  - Identical beat ordering, latency, flush and counter behaviour.

## Structure
- Shared package `pipe_pkg`: state enum typedef (`PIPE_EMPTY`, `PIPE_FULL`, `PIPE_SKID`), default width constants, `pipe_beat_t` packing helper for ctrl/data concatenation.
- One sub-module, `pipe_sat_cnt`: parametrised saturating counter with increment and clear, used for `stall_cnt`.

## Test plan
- Reset then stream 8 beats (ctrl=i, data=0x100+i) with `out_ready`=1 → `out_valid` from cycle 1, beats in order, one per cycle, `stall_cnt`=0.
- Skid build: FULL with beat A, hold `out_ready`=0, offer B → `in_ready` falls next cycle. Release `out_ready` → A then B out on consecutive cycles; `stall_cnt`=number of stalled cycles.
- Flush in SKID with `CLEAR_DATA_ON_FLUSH`=1 → next cycle `out_valid`=0, `out_ctrl`=0, `out_data`=0, `in_ready`=1. A beat offered in the flush cycle never appears.
- `CLEAR_DATA_ON_FLUSH`=0, flush with data 0xDEAD held → `out_ctrl`=0, `out_data`=0xDEAD, `out_valid`=0.
- `STALL_CNT_W`=4, hold `out_ready`=0 for 20 cycles → `stall_cnt` stops at 15. Pulse `stall_cnt_clr` concurrent with a stall → next value 0.
- Assert `rst_n`=0 asynchronously mid-stream, between edges → outputs zero immediately, before next `clk` edge.
